// File: rtl/shift_rotate_pkg.sv
// Shared definitions for the shift/rotate unit: op codes, state encoding
// and a small classification helper.
package shift_rotate_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ROR = 3'b000;
  localparam logic [OP_W-1:0] OP_ROL = 3'b001;
  localparam logic [OP_W-1:0] OP_LSR = 3'b010;
  localparam logic [OP_W-1:0] OP_LSL = 3'b011;
  localparam logic [OP_W-1:0] OP_ASR = 3'b100;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Right-moving ops emit q[0]; left-moving ops emit q[W-1].
  function automatic logic op_is_right(input logic [OP_W-1:0] op);
    return (op == OP_ROR) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

  // Reserved codes hold q and leave serial_out untouched.
  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return op <= OP_ASR;
  endfunction

endpackage

// File: rtl/shift_rotate_unit_step.sv
// One single-bit shift/rotate step: next register value and the bit moved out.
module shift_step
  import shift_rotate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [OP_W-1:0]  op,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next_c,
  output logic             out_bit_c,
  output logic             out_vld_c
);

  always_comb begin
    q_next_c = q_i;
    case (op)
      OP_ROR:  q_next_c = {q_i[0], q_i[WIDTH-1:1]};
      OP_ROL:  q_next_c = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      OP_LSR:  q_next_c = {serial_in, q_i[WIDTH-1:1]};
      OP_LSL:  q_next_c = {q_i[WIDTH-2:0], serial_in};
      OP_ASR:  q_next_c = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default: q_next_c = q_i;
    endcase
  end

  // Out-bit depends only on direction; qualify it so reserved ops can be ignored.
  always_comb begin
    out_vld_c = op_is_valid(op);
    out_bit_c = op_is_right(op) ? q_i[0] : q_i[WIDTH-1];
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-mode shift/rotate register: parallel load plus counted single-bit
// shift/rotate operations under a start/busy/done handshake.
module shift_rotate_unit
  import shift_rotate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  logic             state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             serial_out_q, serial_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_q_c;
  logic             step_bit_c;
  logic             step_vld_c;
  logic             last_step_c;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q_i       (q_q),
    .op        (op_q),
    .serial_in (serial_in),
    .q_next_c  (step_q_c),
    .out_bit_c (step_bit_c),
    .out_vld_c (step_vld_c)
  );

  assign last_step_c = (cnt_q == AMT_W'(1));

  // State and datapath registers; reset wins over everything, mid-run included.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= OP_ROR;
      q_q          <= '0;
      serial_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      q_q          <= q_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next state: load aborts a run and beats start; zero-length starts never enter RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!load && start && (amount != '0)) state_d = ST_RUN;
      ST_RUN:  if (load || last_step_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, counter and handshake outputs.
  always_comb begin
    q_d          = q_q;
    serial_out_d = serial_out_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    done_d       = 1'b0;

    if (load) begin
      q_d   = load_data;
      cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d   = op;
            cnt_d  = amount;
            done_d = (amount == '0);
          end
        end
        ST_RUN: begin
          q_d    = step_q_c;
          cnt_d  = cnt_q - AMT_W'(1);
          done_d = last_step_c;
          if (step_vld_c) serial_out_d = step_bit_c;
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  assign q          = q_q;
  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
